// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: controller around a UART receiver core.
//   Owns the active frame configuration (baud divisor, stop bits, parity).
//   Generates the baud tick. Arms and disarms the receiver. Buffers received
//   bytes in a small FIFO that drains over a valid/ready stream.
//   New configuration is staged as "pending" and is only made active in a
//   dedicated APPLY state. The receiver is idle in that state, so a frame
//   never sees its settings change part-way through.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   arm receiver; when low, stop after current frame
//   cfg_wr                   strobe: latch cfg_div/cfg_stop_bits/cfg_parity
//   cfg_div                  clk cycles per baud tick minus one
//   cfg_stop_bits            1 or 2 (0 and 3 read as 1)
//   cfg_parity               0 none, 1 even, 2 odd (3 reads as none)
//   rx_busy, rx_done         receiver status; rx_done is a one-cycle pulse
//   rx_data, rx_err          received byte and its error flag, valid with rx_done
//   rx_start                 receiver enable
//   baud_tick                one-cycle pulse per baud period
//   stop_bits, parity        active settings presented to the receiver
//   m_valid/m_ready          byte stream handshake out of the FIFO
//   m_data/m_err             head-of-FIFO byte and its error flag
//   overrun                  sticky "byte dropped on full FIFO"; cleared by cfg_wr
//   fifo_count               FIFO occupancy
module uart_rx_ctrl #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          cfg_wr,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_stop_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_err,
  output logic                          rx_start,
  output logic                          baud_tick,
  output logic [1:0]                    stop_bits,
  output logic [1:0]                    parity,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic                          m_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 9;  // {err, data}

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARM   = 2'd1,
    ST_RECV  = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic                 rx_start_q, rx_start_d;
  logic                 apply_c;

  logic                 pend_q, pend_d;
  logic [DIV_W-1:0]     pend_div_q, pend_div_d;
  logic [1:0]           pend_stop_q, pend_stop_d;
  logic [1:0]           pend_par_q, pend_par_d;

  logic [DIV_W-1:0]     act_div_q, act_div_d;
  logic [1:0]           act_stop_q, act_stop_d;
  logic [1:0]           act_par_q, act_par_d;

  logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic                 baud_tick_q, baud_tick_d;

  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 m_valid_q, m_valid_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic                 overrun_q, overrun_d;

  logic                 push_c;
  logic                 pop_c;
  logic                 full_c;
  logic                 push_ok_c;
  logic [ENTRY_W-1:0]   rx_entry_c;

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    apply_c = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (pend_q) begin
          state_d = ST_APPLY;
        end else if (enable) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // A starting frame wins over pending config; config waits for the next idle gap.
        if (rx_busy) begin
          state_d = ST_RECV;
        end else if (pend_q) begin
          state_d = ST_APPLY;
        end else if (!enable) begin
          state_d = ST_OFF;
        end
      end
      ST_RECV: begin
        if (rx_done) begin
          state_d = enable ? ST_ARM : ST_OFF;
        end
      end
      ST_APPLY: begin
        apply_c = 1'b1;
        state_d = enable ? ST_ARM : ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
    // Registered copy of the state decode, so rx_start lines up with state_q.
    rx_start_d = (state_d == ST_ARM) || (state_d == ST_RECV);
  end

  // ---------------------------------------------------------------------------
  // Pending / active configuration
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_stop_d = pend_stop_q;
    pend_par_d  = pend_par_q;
    act_div_d   = act_div_q;
    act_stop_d  = act_stop_q;
    act_par_d   = act_par_q;

    if (apply_c) begin
      act_div_d  = pend_div_q;
      act_stop_d = pend_stop_q;
      act_par_d  = pend_par_q;
      pend_d     = 1'b0;
    end

    // Applied after the APPLY copy so a write landing in APPLY stays pending.
    if (cfg_wr) begin
      pend_d      = 1'b1;
      pend_div_d  = cfg_div;
      pend_stop_d = (cfg_stop_bits == 2'd2) ? 2'd2 : 2'd1;
      pend_par_d  = (cfg_parity == 2'd3) ? 2'd0 : cfg_parity;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud generator: tick in the cycle the counter sits at zero
  // ---------------------------------------------------------------------------
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    if (apply_c) begin
      baud_cnt_d = pend_div_q;
    end else if (baud_cnt_q == '0) begin
      baud_cnt_d = act_div_q;
    end else begin
      baud_cnt_d = baud_cnt_q - DIV_W'(1);
    end
    baud_tick_d = (baud_cnt_d == '0);
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  assign rx_entry_c = {rx_err, rx_data};
  assign push_c     = (state_q == ST_RECV) && rx_done;
  assign pop_c      = m_valid_q && m_ready;
  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok_c  = push_c && (!full_c || pop_c);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push_ok_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (cfg_wr) begin
      overrun_d = 1'b0;
    end
    if (push_c && !push_ok_c) begin
      overrun_d = 1'b1;
    end

    m_valid_d = (count_d != '0);

    // Head register mirrors the entry at the new read pointer, including a
    // byte written on this same edge.
    if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
      head_d = rx_entry_c;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= rx_entry_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Register update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      rx_start_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_stop_q <= 2'd1;
      pend_par_q  <= 2'd0;
      act_div_q   <= '0;
      act_stop_q  <= 2'd1;
      act_par_q   <= 2'd0;
      baud_cnt_q  <= '0;
      baud_tick_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      m_valid_q   <= 1'b0;
      head_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_start_q  <= rx_start_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_stop_q <= pend_stop_d;
      pend_par_q  <= pend_par_d;
      act_div_q   <= act_div_d;
      act_stop_q  <= act_stop_d;
      act_par_q   <= act_par_d;
      baud_cnt_q  <= baud_cnt_d;
      baud_tick_q <= baud_tick_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      m_valid_q   <= m_valid_d;
      head_q      <= head_d;
      overrun_q   <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_start   = rx_start_q;
  assign baud_tick  = baud_tick_q;
  assign stop_bits  = act_stop_q;
  assign parity     = act_par_q;
  assign m_valid    = m_valid_q;
  assign m_data     = head_q[7:0];
  assign m_err      = head_q[8];
  assign overrun    = overrun_q;
  assign fifo_count = count_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DIV_W, default 16, width of baud divisor.
REQ-002 Parameter: FIFO_DEPTH, default 4, receive byte FIFO entries, power of two, >= 2.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  1 = controller arms receiver; 0 = stop after current frame.
REQ-006 cfg_wr  input  1  single-cycle strobe loading cfg_div/cfg_stop_bits/cfg_parity into pending config.
REQ-007 cfg_div  input  DIV_W  clk cycles per baud tick minus one.
REQ-008 cfg_stop_bits  input  2  stop bits (1 or 2; 0 and 3 treated as 1).
REQ-009 cfg_parity  input  2  0 none, 1 even, 2 odd, 3 treated as none.
REQ-010 rx_busy  input  1  receiver frame in progress.
REQ-011 rx_done  input  1  receiver frame complete, one cycle, rx_data valid.
REQ-012 rx_data  input  8  received byte.
REQ-013 rx_err  input  1  parity/framing error, valid with rx_done.
REQ-014 rx_start  output  1  receiver enable.
REQ-015 baud_tick  output  1  one-cycle pulse per baud period.
REQ-016 stop_bits  output  2  active stop-bit setting to receiver.
REQ-017 parity  output  2  active parity setting to receiver.
REQ-018 m_valid / m_ready / m_data[7:0] / m_err  output/input/output/output  byte stream out of FIFO.
REQ-019 overrun  output  1  sticky: byte dropped because FIFO full; cleared by cfg_wr.
REQ-020 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-021 FSM states SHALL be OFF, ARM, RECV, APPLY.
REQ-022 OFF: rx_start=0; -> APPLY if pending config exists, else -> ARM when enable=1.
REQ-023 ARM: rx_start=1; -> RECV when rx_busy=1; -> OFF when enable=0 and rx_busy=0; -> APPLY when pending config exists and rx_busy=0.
REQ-024 RECV: rx_start=1; -> ARM on rx_done if enable=1, else -> OFF; rx_done ignored in all other states.
REQ-025 APPLY: one cycle, copies pending config to active config and clears pending flag; -> ARM if enable=1 else OFF; rx_start=0.
REQ-026 Active config SHALL never change while rx_busy=1 or in RECV.
REQ-027 cfg_wr in any state SHALL overwrite pending config (last write wins) and set pending flag; cfg_wr in the APPLY cycle SHALL remain pending for a later APPLY.
REQ-028 Baud counter SHALL load active divisor and decrement each cycle; baud_tick=1 in the cycle count==0, then reload; divisor 0 SHALL give baud_tick every cycle.
REQ-029 Baud counter SHALL reload from new divisor in the APPLY cycle, first tick divisor+1 cycles later.
REQ-030 On rx_done in RECV, {rx_err, rx_data} SHALL be pushed into FIFO the same edge; visible on m_data/m_err next cycle.
REQ-031 Pop SHALL occur when m_valid=1 and m_ready=1; m_valid = (fifo_count != 0).
REQ-032 Push when full SHALL drop the byte and set overrun, unless a pop occurs the same cycle, in which case the push SHALL succeed.
REQ-033 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-034 Push into empty FIFO with m_ready=1 SHALL not bypass; data appears the following cycle.

Reset
REQ-035 On rst: state OFF, rx_start=0, baud_tick=0, active stop_bits=1, parity=0, divisor=0, pending flag=0, FIFO empty, m_valid=0, fifo_count=0, overrun=0.
REQ-036 rst asserted mid-frame SHALL discard FIFO contents and pending config immediately, no further outputs until released.

Verification
REQ-037 cfg_wr div=3, parity=1, stop=2; enable=1 -> APPLY then ARM, baud_tick every 4 cycles, parity=1, stop_bits=2.
REQ-038 In RECV, cfg_wr div=9 -> stop_bits/parity/div unchanged until after rx_done, then APPLY, tick period 10.
REQ-039 rx_done with rx_data=0xA5, rx_err=0, m_ready=0 -> next cycle m_valid=1, m_data=0xA5, fifo_count=1.
REQ-040 Five rx_done bytes 0x01..0x05, m_ready=0, depth 4 -> fifo_count=4, overrun=1, pop order 0x01..0x04.
REQ-041 FIFO full, rx_done 0x77 with m_ready=1 same cycle -> no overrun, fifo_count stays 4, 0x77 last popped.
REQ-042 rst asserted during RECV with 2 bytes buffered -> m_valid=0, fifo_count=0, rx_start=0 while rst high.
